// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller: op codes, FSM encoding, default width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Codes 0..3 are the iterative mul/div ops; 6 and 7 are unused and ignored.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// One restoring-division step: shift the next dividend bit into the partial remainder and trial-subtract.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < divisor keeps shifted below 2*divisor, so diff[WIDTH] is exactly the borrow.
  always_comb begin
    shifted = {rem_i, quot_i[WIDTH-1]};
    diff    = shifted - {1'b0, divisor_i};
    if (diff[WIDTH]) begin
      rem_o  = shifted[WIDTH-1:0];
      quot_o = {quot_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o  = diff[WIDTH-1:0];
      quot_o = {quot_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO writer for the EX stage: iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
// Define MDU_FAST_MUL_EN to replace the iterative multiply with a single-cycle product.
module hilo_mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             annul_i,
  output logic             stall_o,
  output logic             done_o,
  output logic             hi_we_o,
  output logic             lo_we_o,
  output logic [WIDTH-1:0] hi_data_o,
  output logic [WIDTH-1:0] lo_data_o,
  output logic [1:0]       dbg_state_o
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opd;
  logic             div_q, neg_res, neg_rem;

  logic             op_signed, op_is_div, sa, sb, accept;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] src_hi, src_lo, src_opd, nxt_hi, nxt_lo;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo;
  logic             step_div;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  assign op_signed = (op_i == MDU_MULT) || (op_i == MDU_DIV);
  assign op_is_div = (op_i == MDU_DIV) || (op_i == MDU_DIVU);
  assign sa        = op_signed & opa_i[WIDTH-1];
  assign sb        = op_signed & opb_i[WIDTH-1];
  assign abs_a     = sa ? -opa_i : opa_i;
  assign abs_b     = sb ? -opb_i : opb_i;
  assign accept    = (state == ST_IDLE) && start_i && is_muldiv(op_i);

  // Handshake: EX holds start_i/op_i/operands steady while stall_o is high; stall_o
  // rises combinationally on an accepted mul/div and drops in DONE so EX advances there.
  assign stall_o     = accept || (state == ST_MUL) || (state == ST_DIV);
  assign dbg_state_o = state;

  // The accept cycle performs the first iteration on the fresh magnitudes.
  always_comb begin
    if (state == ST_IDLE) begin
      src_hi   = '0;
      src_lo   = op_is_div ? abs_a : abs_b;
      src_opd  = op_is_div ? abs_b : abs_a;
      step_div = op_is_div;
    end else begin
      src_hi   = acc_hi;
      src_lo   = acc_lo;
      src_opd  = opd;
      step_div = (state == ST_DIV);
    end
  end

  assign mul_sum = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_opd} : '0);
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], src_lo[WIDTH-1:1]};

  mdu_div_core #(.WIDTH(WIDTH)) u_div_core (
    .rem_i     (src_hi),
    .quot_i    (src_lo),
    .divisor_i (src_opd),
    .rem_o     (div_hi),
    .quot_o    (div_lo)
  );

  assign nxt_hi = step_div ? div_hi : mul_hi;
  assign nxt_lo = step_div ? div_lo : mul_lo;

  // Remainder follows the dividend sign; quotient and product follow the sign difference.
  always_comb begin
    prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    if (div_q) begin
      fix_hi = neg_rem ? -acc_hi : acc_hi;
      fix_lo = neg_res ? -acc_lo : acc_lo;
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opd       <= '0;
      div_q     <= 1'b0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      done_o    <= 1'b0;
      hi_we_o   <= 1'b0;
      lo_we_o   <= 1'b0;
      hi_data_o <= '0;
      lo_data_o <= '0;
    end else begin
      done_o  <= 1'b0;
      hi_we_o <= 1'b0;
      lo_we_o <= 1'b0;
      if (annul_i) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_i && (op_i == MDU_MTHI)) begin
              hi_we_o   <= 1'b1;
              hi_data_o <= opa_i;
            end else if (start_i && (op_i == MDU_MTLO)) begin
              lo_we_o   <= 1'b1;
              lo_data_o <= opa_i;
            end else if (accept) begin
              div_q   <= op_is_div;
              neg_res <= sa ^ sb;
              neg_rem <= sa;
              if (op_is_div && (opb_i == '0)) begin
                acc_hi  <= opa_i;
                acc_lo  <= '1;
                neg_res <= 1'b0;
                neg_rem <= 1'b0;
                state   <= ST_DONE;
`ifdef MDU_FAST_MUL_EN
              end else if (!op_is_div) begin
                acc_hi <= fast_prod[2*WIDTH-1:WIDTH];
                acc_lo <= fast_prod[WIDTH-1:0];
                state  <= ST_DONE;
`endif
              end else begin
                acc_hi <= nxt_hi;
                acc_lo <= nxt_lo;
                opd    <= src_opd;
                cnt    <= CNT_W'(1);
                state  <= op_is_div ? ST_DIV : ST_MUL;
              end
            end
          end
          ST_MUL, ST_DIV: begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state <= ST_DONE;
            end
          end
          default: begin
            done_o    <= 1'b1;
            hi_we_o   <= 1'b1;
            lo_we_o   <= 1'b1;
            hi_data_o <= fix_hi;
            lo_data_o <= fix_lo;
            cnt       <= '0;
            state     <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Directed bench for hilo_mdu_ctrl: mul/div/MT vectors, divide-by-zero, overflow, annul and async reset.
module tb_hilo_mdu_ctrl;
  import mdu_pkg::*;

  localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT   = 2;
  localparam int MUL_STALL = 1;
`else
  localparam int MUL_LAT   = 33;
  localparam int MUL_STALL = 32;
`endif

  // clock / reset
  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         start_i = 1'b0;
  logic         annul_i = 1'b0;
  logic [2:0]   op_i    = 3'd0;
  logic [W-1:0] opa_i   = '0;
  logic [W-1:0] opb_i   = '0;
  logic         stall_o, done_o, hi_we_o, lo_we_o;
  logic [W-1:0] hi_data_o, lo_data_o;
  logic [1:0]   dbg_state_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*W-1:0] exp_q[$];

  always #5 clk = ~clk;

  hilo_mdu_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .op_i        (op_i),
    .opa_i       (opa_i),
    .opb_i       (opb_i),
    .annul_i     (annul_i),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .hi_we_o     (hi_we_o),
    .lo_we_o     (lo_we_o),
    .hi_data_o   (hi_data_o),
    .lo_data_o   (lo_data_o),
    .dbg_state_o (dbg_state_o)
  );

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // driver: issue one op at a negedge, hold it while EX would be stalled, capture the write
  task automatic do_vec(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input int elat, input int estall);
    int lat, stalls;
    logic seen, ghw, glw, gdn, ehw, elw, edn;
    logic [W-1:0] ghi, glo;
    logic [2*W-1:0] e;
    exp_q.push_back({ehi, elo});
    start_i = 1'b1; op_i = op; opa_i = a; opb_i = b;
    lat = 0; stalls = 0; seen = 1'b0;
    ghw = 1'b0; glw = 1'b0; gdn = 1'b0; ghi = '0; glo = '0;
    for (int n = 0; n < 60 && !seen; n++) begin
      #1;
      if (stall_o) stalls++;
      next_cycle();
      lat = n + 1;
      if (hi_we_o || lo_we_o) begin
        seen = 1'b1;
        ghw = hi_we_o; glw = lo_we_o; gdn = done_o;
        ghi = hi_data_o; glo = lo_data_o;
      end
    end
    start_i = 1'b0;
    check_val({tag, " write_seen"}, W'(seen), W'(1));
    check_val({tag, " latency"}, W'(lat), W'(elat));
    check_val({tag, " stall_cycles"}, W'(stalls), W'(estall));
    e   = exp_q.pop_front();
    ehw = (op != MDU_MTLO);
    elw = (op != MDU_MTHI);
    edn = is_muldiv(op);
    check_val({tag, " hi_we"}, W'(ghw), W'(ehw));
    check_val({tag, " lo_we"}, W'(glw), W'(elw));
    check_val({tag, " done"}, W'(gdn), W'(edn));
    if (ehw) check_val({tag, " hi_data"}, ghi, e[2*W-1:W]);
    if (elw) check_val({tag, " lo_data"}, glo, e[W-1:0]);
    next_cycle();
    check_val({tag, " done_pulse_end"}, W'(done_o), W'(0));
    check_val({tag, " we_end"}, W'(hi_we_o | lo_we_o), W'(0));
  endtask

  initial begin
    int writes;
    #1;
    check_val("reset stall", W'(stall_o), W'(0));
    check_val("reset done", W'(done_o), W'(0));
    check_val("reset we", W'({hi_we_o, lo_we_o}), W'(0));
    check_val("reset hi_data", hi_data_o, '0);
    check_val("reset lo_data", lo_data_o, '0);
    check_val("reset state", W'(dbg_state_o), W'(ST_IDLE));
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    do_vec("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT, MUL_STALL);
    do_vec("mult_m3x7", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT, MUL_STALL);
    do_vec("mult_m1xm1", MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, MUL_LAT, MUL_STALL);
    do_vec("div_m7d2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 32);
    do_vec("div_7dm2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 33, 32);
    do_vec("divu_100d7", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, 32);
    do_vec("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, 32);
    do_vec("divu_by0", MDU_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 2, 1);
    do_vec("div_neg_by0", MDU_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 2, 1);
    do_vec("mthi", MDU_MTHI, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'h0, 1, 0);

    // annul a DIVU at cycle 10, then confirm no write follows
    start_i = 1'b1; op_i = MDU_DIVU; opa_i = 32'd1000; opb_i = 32'd3;
    repeat (10) next_cycle();
    annul_i = 1'b1;
    next_cycle();
    start_i = 1'b0; annul_i = 1'b0;
    #1;
    check_val("annul stall", W'(stall_o), W'(0));
    check_val("annul state", W'(dbg_state_o), W'(ST_IDLE));
    check_val("annul we", W'({hi_we_o, lo_we_o, done_o}), W'(0));
    writes = 0;
    repeat (40) begin
      next_cycle();
      if (hi_we_o || lo_we_o || done_o) writes++;
    end
    check_val("annul no_write", W'(writes), W'(0));
    do_vec("mtlo_after_annul", MDU_MTLO, 32'hCAFE_F00D, 32'd0, 32'h0, 32'hCAFE_F00D, 1, 0);

    // async reset in MUL cycle 5
    start_i = 1'b1; op_i = MDU_MULT; opa_i = 32'd5; opb_i = 32'd6;
    repeat (5) next_cycle();
    rst_n = 1'b0; start_i = 1'b0;
    #1;
    check_val("rst_mid stall", W'(stall_o), W'(0));
    check_val("rst_mid flags", W'({done_o, hi_we_o, lo_we_o}), W'(0));
    check_val("rst_mid hi_data", hi_data_o, '0);
    check_val("rst_mid lo_data", lo_data_o, '0);
    check_val("rst_mid state", W'(dbg_state_o), W'(ST_IDLE));
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    do_vec("multu_after_rst", MDU_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, MUL_LAT, MUL_STALL);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
